// File: rtl/tx_control_module.sv
// ----------------------------------------------------------------------------
// tx_control_module : UART transmit framing stage, one line bit per BPS_CLK tick
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tx_control_module #(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TX_En_Sig,
    input  logic [7:0] TX_Data,
    input  logic       BPS_CLK,
    output logic       Count_Sig,
    output logic       TX_Pin_Out,
    output logic       TX_Busy,
    output logic       TX_Done_Sig
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        FINISH     = 3'd5
    } state_t;

    localparam logic [1:0] STOP_LAST  = 2'(STOP_BITS - 1);
    localparam logic       PARITY_INV = (PARITY_ODD != 0);
    localparam logic       USE_PARITY = (PARITY_EN != 0);

    state_t     state, state_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [1:0] stop_cnt, stop_cnt_nxt;
    logic [7:0] shift_reg, shift_reg_nxt;
    logic       parity_bit, parity_bit_nxt;
    logic       count_nxt, pin_nxt, busy_nxt, done_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            bit_idx     <= 3'd0;
            stop_cnt    <= 2'd0;
            shift_reg   <= 8'd0;
            parity_bit  <= 1'b0;
            Count_Sig   <= 1'b0;
            TX_Pin_Out  <= 1'b1;
            TX_Busy     <= 1'b0;
            TX_Done_Sig <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_idx     <= bit_idx_nxt;
            stop_cnt    <= stop_cnt_nxt;
            shift_reg   <= shift_reg_nxt;
            parity_bit  <= parity_bit_nxt;
            Count_Sig   <= count_nxt;
            TX_Pin_Out  <= pin_nxt;
            TX_Busy     <= busy_nxt;
            TX_Done_Sig <= done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_idx_nxt    = bit_idx;
        stop_cnt_nxt   = stop_cnt;
        shift_reg_nxt  = shift_reg;
        parity_bit_nxt = parity_bit;
        count_nxt      = Count_Sig;
        pin_nxt        = TX_Pin_Out;
        busy_nxt       = TX_Busy;
        done_nxt       = 1'b0;

        unique case (state)
            IDLE: begin
                // BPS_CLK is deliberately ignored here
                pin_nxt = 1'b1;
                if (TX_En_Sig) begin
                    shift_reg_nxt  = TX_Data;
                    parity_bit_nxt = (^TX_Data) ^ PARITY_INV;
                    count_nxt      = 1'b1;
                    busy_nxt       = 1'b1;
                    state_nxt      = WAIT_START;
                end
            end
            WAIT_START: begin
                if (BPS_CLK) begin
                    pin_nxt     = 1'b0;
                    bit_idx_nxt = 3'd0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (BPS_CLK) begin
                    pin_nxt     = shift_reg[bit_idx];
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        stop_cnt_nxt = 2'd0;
                        state_nxt    = USE_PARITY ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (BPS_CLK) begin
                    pin_nxt      = parity_bit;
                    stop_cnt_nxt = 2'd0;
                    state_nxt    = STOP;
                end
            end
            STOP: begin
                if (BPS_CLK) begin
                    pin_nxt      = 1'b1;
                    stop_cnt_nxt = stop_cnt + 2'd1;
                    if (stop_cnt == STOP_LAST) begin
                        state_nxt = FINISH;
                    end
                end
            end
            FINISH: begin
                // This tick closes the final stop bit after a full bit period
                if (BPS_CLK) begin
                    pin_nxt   = 1'b1;
                    count_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_tx_control_module.sv
// ----------------------------------------------------------------------------
// tb_tx_control_module : four parameter variants driven in parallel against a frame-queue model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tx_control_module;

    // instance 0: 8N1, 1: even parity, 2: odd parity, 3: two stop bits
    localparam logic [3:0] PE_V = 4'b0110;
    localparam logic [3:0] PO_V = 4'b0100;
    localparam logic [7:0] SB_V = {2'd2, 2'd1, 2'd1, 2'd1};

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] data;
    logic [3:0] bps;
    logic [3:0] count_o, pin_o, busy_o, done_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        tx_control_module #(
            .PARITY_EN (int'(PE_V[g])),
            .PARITY_ODD(int'(PO_V[g])),
            .STOP_BITS (int'(SB_V[2*g +: 2]))
        ) u_dut (
            .CLK        (clk),
            .RST_N      (rst_n),
            .TX_En_Sig  (en),
            .TX_Data    (data),
            .BPS_CLK    (bps[g]),
            .Count_Sig  (count_o[g]),
            .TX_Pin_Out (pin_o[g]),
            .TX_Busy    (busy_o[g]),
            .TX_Done_Sig(done_o[g])
        );
    end

    typedef struct {
        logic [7:0] data;
        logic       exp_even;
        logic       exp_odd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // baud generator emulation and stimulus mode
    int   period = 5208;
    int   half   = 2604;
    bit   rand_mode = 1'b0;
    int   bcnt[4];
    logic [3:0] cnt_seen;

    // reference model: pending line bits as a shift-out queue
    logic [15:0] m_frame[4];
    int          m_len[4];
    logic [3:0]  m_busy, m_pin, m_done, accepted, tick_now;

    // observation
    int   tickcnt[4];
    int   done_tick[4];
    logic cap[4][16];
    logic [3:0] done_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_frame[i] = '0;
            m_len[i]   = 0;
            bcnt[i]    = 0;
            tickcnt[i] = 0;
        end
        m_busy = '0; m_pin = '1; m_done = '0; accepted = '0; tick_now = '0;
        cnt_seen = '0; done_seen = '0;
    endtask

    task automatic build_frame(input int i, input logic [7:0] d);
        logic [15:0] f;
        int n;
        f = '0;
        n = 0;
        f[n] = 1'b0; n++;
        for (int b = 0; b < 8; b++) begin f[n] = d[b]; n++; end
        if (PE_V[i]) begin f[n] = (^d) ^ PO_V[i]; n++; end
        for (int s = 0; s < int'(SB_V[2*i +: 2]); s++) begin f[n] = 1'b1; n++; end
        m_frame[i] = f;
        m_len[i]   = n;
    endtask

    task automatic model_edge(input int i);
        accepted[i] = 1'b0;
        m_done[i]   = 1'b0;
        if (!m_busy[i]) begin
            if (en) begin
                build_frame(i, data);
                m_busy[i]   = 1'b1;
                accepted[i] = 1'b1;
            end
        end else if (bps[i]) begin
            if (m_len[i] > 0) begin
                m_pin[i]   = m_frame[i][0];
                m_frame[i] = m_frame[i] >> 1;
                m_len[i]--;
            end else begin
                m_done[i] = 1'b1;
                m_busy[i] = 1'b0;
                m_pin[i]  = 1'b1;
            end
        end
    endtask

    // one clock: inputs already set at the negedge, checked at the next negedge
    task automatic step();
        for (int i = 0; i < 4; i++)
            bps[i] = rand_mode ? ($urandom_range(0, 2) == 0) : (bcnt[i] == half);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            tick_now[i] = bps[i] && m_busy[i];
            model_edge(i);
            if (!cnt_seen[i]) bcnt[i] = 0;
            else if (bcnt[i] == period - 1) bcnt[i] = 0;
            else bcnt[i]++;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({count_o[i], pin_o[i], busy_o[i], done_o[i]} !== {m_busy[i], m_pin[i], m_busy[i], m_done[i]}) begin
                n_fail++;
                $display("FAIL cycle inst%0d {cnt,pin,busy,done}: got %b expected %b at %0t", i,
                         {count_o[i], pin_o[i], busy_o[i], done_o[i]},
                         {m_busy[i], m_pin[i], m_busy[i], m_done[i]}, $time);
            end
            if (accepted[i]) tickcnt[i] = 0;
            if (tick_now[i]) begin
                if (tickcnt[i] < 16) cap[i][tickcnt[i]] = pin_o[i];
                tickcnt[i]++;
            end
            if (done_o[i]) begin
                done_seen[i] = 1'b1;
                done_tick[i] = tickcnt[i];
            end
            cnt_seen[i] = count_o[i];
        end
    endtask

    task automatic run_until_done(input string name, input int budget);
        logic [3:0] want;
        want = m_busy;
        done_seen = '0;
        for (int k = 0; k < budget && ((done_seen & want) != want); k++) step();
        check(name, 32'((done_seen & want) == want), 32'd1);
    endtask

    function automatic logic [7:0] cap_byte(input int i);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = cap[i][b+1];
        return v;
    endfunction

    initial begin
        vec_t vecs[8];
        vecs[0] = '{8'h07, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 1'b1};
        vecs[3] = '{8'hA3, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b1};
        vecs[6] = '{8'hB6, 1'b1, 1'b0};
        vecs[7] = '{8'h01, 1'b1, 1'b0};

        rst_n = 1'b0; en = 1'b0; data = 8'h00; bps = '0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("reset_values_inst%0d", i), {count_o[i], pin_o[i], busy_o[i], done_o[i]}, 4'b0100);
        rst_n = 1'b1;

        // 8N1 at full baud timing, accept on edge 0
        en = 1'b1; data = 8'h55;
        step();
        en = 1'b0; data = 8'hAA;
        check("8n1_count_after_accept", count_o[0], 1'b1);
        done_seen = '0;
        for (int k = 1; k <= 59900; k++) begin
            step();
            if (k == 2604)            check("8n1_line_idle_before_start", pin_o[0], 1'b1);
            if (k == 2605)            check("8n1_start_bit", pin_o[0], 1'b0);
            if (k == 2605 + 9*5208 - 1) check("8n1_bit7", pin_o[0], 1'b0);
            if (k == 2605 + 9*5208)   check("8n1_stop_rise", pin_o[0], 1'b1);
            if (k == 54684)           check("8n1_no_early_done", done_o[0], 1'b0);
            if (k == 54685)           check("8n1_done_cnt_busy", {done_o[0], count_o[0], busy_o[0]}, 3'b100);
            if (k == 54686)           check("8n1_done_one_cycle", done_o[0], 1'b0);
        end
        check("8n1_all_done", done_seen, 4'b1111);
        check("8n1_data_bits", cap_byte(0), 8'h55);

        // table of frames at a fast baud
        period = 8; half = 4;
        for (int v = 0; v < 8; v++) begin
            en = 1'b1; data = vecs[v].data;
            step();
            en = 1'b0; data = 8'($urandom);
            run_until_done($sformatf("vec%0d_timeout", v), 400);
            check($sformatf("vec%0d_data", v), cap_byte(0), vecs[v].data);
            check($sformatf("vec%0d_even_parity", v), cap[1][9], vecs[v].exp_even);
            check($sformatf("vec%0d_odd_parity", v), cap[2][9], vecs[v].exp_odd);
            check($sformatf("vec%0d_two_stop", v), {cap[3][9], cap[3][10]}, 2'b11);
            check($sformatf("vec%0d_ticks", v),
                  {8'(done_tick[0]), 8'(done_tick[1]), 8'(done_tick[2]), 8'(done_tick[3])},
                  {8'd11, 8'd12, 8'd12, 8'd12});
        end

        // request while busy must not disturb the frame in flight
        en = 1'b1; data = 8'h00;
        step();
        en = 1'b0;
        repeat (30) step();
        en = 1'b1; data = 8'hFF;
        step();
        en = 1'b0;
        run_until_done("busy_timeout", 400);
        check("busy_data_unchanged", cap_byte(0), 8'h00);
        check("busy_parity_unchanged", cap[1][9], 1'b0);
        check("busy_ticks", done_tick[0], 11);

        // back-to-back with TX_En_Sig held high
        en = 1'b1; data = 8'h3C;
        step();
        begin
            int k;
            for (k = 0; k < 400 && !done_o[0]; k++) step();
            check("b2b_first_done", done_o[0], 1'b1);
        end
        check("b2b_count_low_gap", count_o[0], 1'b0);
        step();
        check("b2b_reaccept", {count_o[0], busy_o[0], done_o[0]}, 3'b110);
        en = 1'b0;
        repeat (4) step();
        check("b2b_before_start", pin_o[0], 1'b1);
        step();
        check("b2b_start_bit", pin_o[0], 1'b0);
        run_until_done("b2b_timeout", 400);
        check("b2b_second_data", cap_byte(0), 8'h3C);

        // random requests, data and bit ticks
        rand_mode = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            en   = ($urandom_range(0, 5) == 0);
            data = 8'($urandom);
            step();
        end
        rand_mode = 1'b0;
        en = 1'b0;
        run_until_done("random_drain", 800);

        // asynchronous reset during data bit 3
        en = 1'b1; data = 8'hF0;
        step();
        en = 1'b0;
        for (int k = 0; k < 200 && tickcnt[0] < 5; k++) step();
        check("rst_in_bit3", {busy_o[0], pin_o[0]}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++)
            check($sformatf("rst_midframe_inst%0d", i), {count_o[i], pin_o[i], busy_o[i], done_o[i]}, 4'b0100);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1; data = 8'h81;
        step();
        en = 1'b0;
        run_until_done("post_rst_timeout", 400);
        check("post_rst_start", cap[0][0], 1'b0);
        check("post_rst_data", cap_byte(0), 8'h81);
        check("post_rst_ticks", done_tick[0], 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tx_control_module.md
Name: tx_control_module

Overview:
UART transmit framing stage. It sits directly downstream of the tx_bps_module baud generator and consumes its BPS_CLK pulses. It drives that generator's Count_Sig enable. On a request it latches one byte and shifts out a full serial frame on TX_Pin_Out, one bit per BPS_CLK pulse: start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits. It then pulses TX_Done_Sig.

Parameters:
PARITY_EN, 0, 1 = insert a parity bit after data bit 7; 0 = no parity bit
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd
STOP_BITS, 1, number of stop bits; legal values are 1 and 2, other values are unsupported

Ports:
CLK  input  1  system clock (50 MHz in the target design)
RST_N  input  1  asynchronous active-low reset
TX_En_Sig  input  1  transmit request, level-sampled; accepted only in IDLE
TX_Data  input  8  byte to send; sampled on the accept cycle only
BPS_CLK  input  1  one-cycle bit-tick from tx_bps_module
Count_Sig  output  1  enable to tx_bps_module; high for the whole frame
TX_Pin_Out  output  1  serial line; idles high
TX_Busy  output  1  high from accept until the done pulse, inclusive of the accept edge
TX_Done_Sig  output  1  one-cycle pulse at end of frame

Behaviour:
- All outputs are registered.
- Reset values: Count_Sig=0, TX_Pin_Out=1, TX_Busy=0, TX_Done_Sig=0, state=IDLE, bit index=0, shift register=0.
- Reset is asynchronous and may arrive mid-frame. It returns the block to the reset values immediately; the line goes high and the frame is aborted.
- States: IDLE, WAIT_START, DATA, PARITY, STOP, FINISH.
- IDLE: TX_Pin_Out=1.
  - When TX_En_Sig=1: latch TX_Data into the shift register, compute the parity bit (XOR of data bits, inverted when PARITY_ODD=1), set Count_Sig=1 and TX_Busy=1, then go to WAIT_START.
  - TX_Done_Sig is 0 in every cycle except the done cycle.
- WAIT_START: on BPS_CLK, set TX_Pin_Out<=0 (start bit), bit index<=0, go to DATA.
- DATA: on BPS_CLK, set TX_Pin_Out<=data[index] and index<=index+1.
  - After driving index 7: go to PARITY if PARITY_EN=1, else go to STOP with the stop counter at 0.
- PARITY: on BPS_CLK, set TX_Pin_Out<=parity bit, then go to STOP.
- STOP: on BPS_CLK, set TX_Pin_Out<=1 and increment the stop counter. Go to FINISH once STOP_BITS stop bits have been driven.
- FINISH: on BPS_CLK (the last stop bit has now lasted a full period):
  - Count_Sig<=0, TX_Busy<=0, TX_Done_Sig<=1 for exactly one cycle.
  - Go to IDLE; TX_Pin_Out stays 1.
- Without a BPS_CLK pulse, all non-IDLE states hold every output.
- Pulse count per frame is 10 + PARITY_EN + STOP_BITS.
- TX_En_Sig is ignored while TX_Busy=1. Changes on TX_Data after the accept cycle have no effect.
- Back-to-back frames:
  - If TX_En_Sig is still high in the cycle after the done pulse (state IDLE), a new frame is accepted.
  - Count_Sig is therefore low for exactly one cycle between frames, which resets the baud counter.
- BPS_CLK arriving while in IDLE is ignored.

Test Plan:
- 8N1 timing, with tx_bps_module attached (period 5208 cycles, tick at count 2604). Defaults; TX_En_Sig held high for one cycle at edge 0 with TX_Data=0x55.
  - Count_Sig=1 after edge 0.
  - TX_Pin_Out falls after edge 2605.
  - Data bits are 1,0,1,0,1,0,1,0, each 5208 cycles wide.
  - Stop bit rises at edge 2605+9*5208.
  - TX_Done_Sig is high for exactly one cycle after edge 54685, with Count_Sig=0 and TX_Busy=0 in the same cycle.
- Even parity: PARITY_EN=1, PARITY_ODD=0, TX_Data=0x07 -> parity bit=1, then the stop bit. Done occurs 12 ticks after accept.
- Odd parity: PARITY_EN=1, PARITY_ODD=1, TX_Data=0x07 -> parity bit=0.
- Two stop bits: STOP_BITS=2, TX_Data=0xA3 -> line high for 2*5208 cycles before done. Done occurs 12 ticks after accept.
- Request while busy: pulse TX_En_Sig with TX_Data=0xFF mid-frame while sending 0x00 -> 0xFF is never transmitted and the frame of 0x00 is unchanged.
- Back-to-back: hold TX_En_Sig high with TX_Data=0x3C -> a second frame is accepted the cycle after the done pulse, Count_Sig is low for 1 cycle between frames, and the second start bit begins 2605 cycles after that accept.
- Reset mid-frame: assert RST_N=0 during data bit 3 -> the line and outputs return to reset values immediately. A fresh 0x81 request after release transmits correctly.
